// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - fetch_state_t : fetch FSM encoding (REQ, WAIT, FAULT)
//   - NOP_INSTR     : instruction presented while nothing has been fetched
//   - INSTR_BYTES   : sequential PC step
//   - OPC_*         : opcodes of the control-transfer instructions that
//                     produce redirects downstream
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // True for instructions that can later cause a redirect back into fetch.
    function automatic logic is_control_transfer(input logic [31:0] instr);
        return (instr[6:0] == OPC_BRANCH) ||
               (instr[6:0] == OPC_JAL)    ||
               (instr[6:0] == OPC_JALR);
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-PC selection for instruction fetch.
// Priority: redirect > sequential +INSTR_BYTES > hold. Also flags a
// redirect target that is not word aligned.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   redirect_valid/_pc   : load a new PC from branch/jump resolution
//   advance              : step the PC to the next sequential word
//   pc                   : current fetch PC
//   redirect_misaligned  : redirect this cycle targets a non-word address
module fetch_pc_gen
    import instruction_fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic            redirect_misaligned
);

    logic [XLEN-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (advance) begin
            // Natural XLEN-bit wrap at the top of the address space.
            pc_next = pc + XLEN'(INSTR_BYTES);
        end
    end

    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Front stage of the non-pipelined core. Owns the PC, issues one word fetch
// at a time to instruction memory and presents the returned instruction with
// its PC to decode. Redirects from branch/jump resolution replace the PC and
// discard any in-flight fetch.
//
// Handshakes: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; imem_req_valid may depend combinationally on
// id_ready but never on imem_req_ready. A response is a single-cycle
// imem_rsp_valid pulse, at most one per accepted request. Decode takes the
// output on a cycle where if_valid and id_ready are both high.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   imem_req_valid/_ready     : fetch request handshake
//   imem_addr                 : fetch address (always the current PC)
//   imem_rsp_valid/_data      : fetch response
//   redirect_valid/_pc        : taken branch/jump target
//   id_ready                  : decode consumes the output this cycle
//   if_valid, instruction,
//   out_pc_value              : registered instruction slot toward decode
//   fetch_fault               : sticky misaligned-redirect flag
//   dbg_state                 : current fetch FSM state
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [31:0]     instruction,
    output logic [XLEN-1:0] out_pc_value,
    output logic            fetch_fault,
    output fetch_state_t    dbg_state
);

    fetch_state_t    state;
    logic            kill;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] pc;
    logic            redirect_misaligned;
    logic            req_fire;
    logic            rsp_write;

    // Only request when the output slot is free or leaving this cycle, so a
    // response can never overwrite an instruction decode has not taken.
    assign imem_req_valid = rst && (state == ST_REQ) && (!if_valid || id_ready);
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response lands in the output slot only if it is not stale and no
    // redirect arrives alongside it.
    assign rsp_write = (state == ST_WAIT) && imem_rsp_valid && !kill && !redirect_valid;

    assign dbg_state = state;

    fetch_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk                 (clk),
        .rst                 (rst),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .advance             (rsp_write),
        .pc                  (pc),
        .redirect_misaligned (redirect_misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_REQ;
            kill         <= 1'b0;
            pend_pc      <= RESET_PC;
            if_valid     <= 1'b0;
            instruction  <= NOP_INSTR;
            out_pc_value <= RESET_PC;
            fetch_fault  <= 1'b0;
        end else begin
            if (id_ready) begin
                if_valid <= 1'b0;
            end

            if (redirect_valid) begin
                if_valid    <= 1'b0;
                fetch_fault <= redirect_misaligned;
                // A request already with memory must still be answered; wait
                // for it and throw it away. A misaligned target then parks in
                // FAULT once the drop completes.
                if (((state == ST_WAIT) && !imem_rsp_valid) ||
                    ((state == ST_REQ) && req_fire)) begin
                    kill  <= 1'b1;
                    state <= ST_WAIT;
                end else begin
                    kill  <= 1'b0;
                    state <= redirect_misaligned ? ST_FAULT : ST_REQ;
                end
            end else begin
                case (state)
                    ST_REQ: begin
                        if (req_fire) begin
                            pend_pc <= pc;
                            state   <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rsp_valid) begin
                            if (kill) begin
                                kill  <= 1'b0;
                                state <= fetch_fault ? ST_FAULT : ST_REQ;
                            end else begin
                                instruction  <= imem_rsp_data;
                                out_pc_value <= pend_pc;
                                if_valid     <= 1'b1;
                                state        <= ST_REQ;
                            end
                        end
                    end
                    ST_FAULT: begin
                        state <= ST_FAULT;
                    end
                    default: begin
                        state <= ST_REQ;
                    end
                endcase
            end
        end
    end

endmodule
